// File: rtl/tms_spi_boot_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tms_spi_boot_loader                                                      |
// | Copies the TMS program image from SPI NOR flash (READ 0x03, mode 0) into |
// | the program SRAM and holds the CPU in reset until the image is loaded.   |
// | Optional: define BOOT_CHECKSUM_EN to verify a trailing sum word.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tms_spi_boot_loader #(
    parameter int unsigned WORDS      = 512,
    parameter int unsigned CLK_DIV    = 2,
    parameter logic [23:0] FLASH_ADDR = 24'h000000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        boot_req,
    output logic        spi_csb,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        ram_csb,
    output logic        ram_web,
    output logic [8:0]  ram_addr,
    output logic [31:0] ram_din,
    output logic        cpu_reset_o,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_READ   = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    localparam int unsigned      DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [8:0]       C_LAST_IDX = 9'(WORDS - 1);
    localparam logic [31:0]      C_READ_CMD = {8'h03, FLASH_ADDR};

    logic [2:0]       r_state;
    logic [DIV_W-1:0] r_div;
    logic [4:0]       r_bit;
    logic [8:0]       r_idx;
    logic [31:0]      r_cmd;
    logic [31:0]      r_shift;
    logic             r_spi_csb;
    logic             r_spi_sck;
    logic             r_spi_mosi;
    logic             r_ram_csb;
    logic             r_ram_web;
    logic [8:0]       r_ram_addr;
    logic [31:0]      r_ram_din;
    logic             r_cpu_reset;
    logic             r_busy;
    logic             r_done;
`ifdef BOOT_CHECKSUM_EN
    logic             r_error;
    logic             r_chk;
    logic [31:0]      r_sum;
`endif

    logic        w_tick;
    logic        w_rise;
    logic        w_fall;
    logic        w_start;
    logic        w_last_bit;
    logic [31:0] w_word;

    assign w_tick     = (r_div == C_DIV_LAST);
    assign w_rise     = w_tick & ~r_spi_sck;
    assign w_fall     = w_tick & r_spi_sck;
    assign w_last_bit = w_fall & (r_bit == 5'd31);
    assign w_start    = (r_state == S_IDLE) ||
                        (((r_state == S_DONE) || (r_state == S_ERROR)) && boot_req);
    // Bytes arrive MSB-first in flash order; flash byte 0 lands in bits [7:0].
    assign w_word     = {r_shift[7:0], r_shift[15:8], r_shift[23:16], r_shift[31:24]};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state     <= S_IDLE;
            r_div       <= '0;
            r_bit       <= '0;
            r_idx       <= '0;
            r_cmd       <= '0;
            r_shift     <= '0;
            r_spi_csb   <= 1'b1;
            r_spi_sck   <= 1'b0;
            r_spi_mosi  <= 1'b0;
            r_ram_csb   <= 1'b1;
            r_ram_web   <= 1'b1;
            r_ram_addr  <= '0;
            r_ram_din   <= '0;
            r_cpu_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            r_error     <= 1'b0;
            r_chk       <= 1'b0;
            r_sum       <= '0;
`endif
        end else if (w_start) begin
            r_state     <= S_CMD;
            r_div       <= '0;
            r_bit       <= '0;
            r_idx       <= '0;
            r_cmd       <= {C_READ_CMD[30:0], 1'b0};
            r_spi_csb   <= 1'b0;
            r_spi_sck   <= 1'b0;
            r_spi_mosi  <= C_READ_CMD[31];
            r_ram_csb   <= 1'b1;
            r_ram_web   <= 1'b1;
            r_cpu_reset <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            r_error     <= 1'b0;
            r_chk       <= 1'b0;
            r_sum       <= '0;
`endif
        end else begin
            case (r_state)
                S_CMD: begin
                    r_div <= w_tick ? '0 : r_div + 1'b1;
                    if (w_tick) begin
                        r_spi_sck <= ~r_spi_sck;
                    end
                    // MOSI only moves on the falling SCK edge so it is stable at the rise.
                    if (w_fall) begin
                        r_bit      <= r_bit + 5'd1;
                        r_spi_mosi <= r_cmd[31];
                        r_cmd      <= {r_cmd[30:0], 1'b0};
                        if (r_bit == 5'd31) begin
                            r_spi_mosi <= 1'b0;
                            r_state    <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    r_div <= w_tick ? '0 : r_div + 1'b1;
                    if (w_tick) begin
                        r_spi_sck <= ~r_spi_sck;
                    end
                    if (w_rise) begin
                        r_shift <= {r_shift[30:0], spi_miso};
                    end
                    if (w_fall) begin
                        r_bit <= r_bit + 5'd1;
                    end
                    if (w_last_bit) begin
`ifdef BOOT_CHECKSUM_EN
                        if (r_chk) begin
                            r_spi_csb <= 1'b1;
                            r_busy    <= 1'b0;
                            r_done    <= (w_word == r_sum);
                            r_error   <= (w_word != r_sum);
                            r_state   <= S_FINISH;
                        end else begin
                            r_ram_csb  <= 1'b0;
                            r_ram_web  <= 1'b0;
                            r_ram_addr <= r_idx;
                            r_ram_din  <= w_word;
                            r_state    <= S_WRITE;
                        end
`else
                        r_ram_csb  <= 1'b0;
                        r_ram_web  <= 1'b0;
                        r_ram_addr <= r_idx;
                        r_ram_din  <= w_word;
                        r_state    <= S_WRITE;
`endif
                    end
                end
                S_WRITE: begin
                    r_ram_csb <= 1'b1;
                    r_ram_web <= 1'b1;
                    r_div     <= '0;
`ifdef BOOT_CHECKSUM_EN
                    r_sum     <= r_sum + r_ram_din;
`endif
                    if (r_idx == C_LAST_IDX) begin
`ifdef BOOT_CHECKSUM_EN
                        r_chk   <= 1'b1;
                        r_state <= S_READ;
`else
                        r_spi_csb <= 1'b1;
                        r_spi_sck <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_FINISH;
`endif
                    end else begin
                        r_idx   <= r_idx + 9'd1;
                        r_state <= S_READ;
                    end
                end
                S_FINISH: begin
                    // CPU leaves reset one cycle after done so it never overlaps busy.
                    if (r_done) begin
                        r_cpu_reset <= 1'b0;
                    end
                    r_state <= r_done ? S_DONE : S_ERROR;
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign spi_csb     = r_spi_csb;
    assign spi_sck     = r_spi_sck;
    assign spi_mosi    = r_spi_mosi;
    assign ram_csb     = r_ram_csb;
    assign ram_web     = r_ram_web;
    assign ram_addr    = r_ram_addr;
    assign ram_din     = r_ram_din;
    assign cpu_reset_o = r_cpu_reset;
    assign busy        = r_busy;
    assign done        = r_done;
`ifdef BOOT_CHECKSUM_EN
    assign error       = r_error;
`else
    assign error       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tms_spi_boot_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tms_spi_boot_loader                                                   |
// | Directed bench: flash model with bytes 00..0F, SRAM write monitor.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_tms_spi_boot_loader;

`ifdef BOOT_CHECKSUM_EN
    localparam int C_EXP_RISES = 192;
`else
    localparam int C_EXP_RISES = 160;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic boot_req = 1'b0;
    logic spi_miso = 1'b0;
    logic spi_csb, spi_sck, spi_mosi, ram_csb, ram_web;
    logic [8:0]  ram_addr;
    logic [31:0] ram_din;
    logic cpu_reset_o, busy, done, error;

    logic b_miso = 1'b0;
    logic b_csb, b_sck, b_mosi, b_ram_csb, b_ram_web, b_cpu_reset, b_busy, b_done, b_error;
    logic [8:0]  b_ram_addr;
    logic [31:0] b_ram_din;

    always #5 clk = ~clk;

    tms_spi_boot_loader #(.WORDS(4), .CLK_DIV(2), .FLASH_ADDR(24'h000000)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .boot_req(boot_req),
        .spi_csb(spi_csb), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .ram_csb(ram_csb), .ram_web(ram_web), .ram_addr(ram_addr), .ram_din(ram_din),
        .cpu_reset_o(cpu_reset_o), .busy(busy), .done(done), .error(error)
    );

    tms_spi_boot_loader #(.WORDS(1), .CLK_DIV(2), .FLASH_ADDR(24'h010000)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .boot_req(1'b0),
        .spi_csb(b_csb), .spi_sck(b_sck), .spi_mosi(b_mosi), .spi_miso(b_miso),
        .ram_csb(b_ram_csb), .ram_web(b_ram_web), .ram_addr(b_ram_addr), .ram_din(b_ram_din),
        .cpu_reset_o(b_cpu_reset), .busy(b_busy), .done(b_done), .error(b_error)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic t_check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Flash model: 20-byte image, data phase begins after 32 command rises.
    logic [7:0]  flash_mem [0:19];
    logic [31:0] cmd_cap = '0;
    int          rise_cnt = 0;
    int          total_rise = 0;
    int          cyc = 0;
    int          t_csb_fall = 0, t_rise0 = 0, t_rise1 = 0;

    always @(posedge clk) cyc++;

    always @(negedge spi_csb) begin
        rise_cnt   = 0;
        cmd_cap    = '0;
        t_csb_fall = cyc;
    end

    always @(posedge spi_sck) begin
        if (spi_csb === 1'b0) begin
            if (rise_cnt < 32) cmd_cap = {cmd_cap[30:0], spi_mosi};
            if (rise_cnt == 0) t_rise0 = cyc;
            if (rise_cnt == 1) t_rise1 = cyc;
            rise_cnt++;
            total_rise++;
        end
    end

    always @(negedge spi_sck) begin : flash_drive
        int         k;
        logic [7:0] bv;
        if (spi_csb === 1'b0 && rise_cnt >= 32) begin
            k  = rise_cnt - 32;
            bv = (k / 8 < 20) ? flash_mem[k / 8] : 8'h00;
            spi_miso = bv[7 - (k % 8)];
        end
    end

    logic [31:0] b_cmd = '0;
    int          b_rise = 0;
    always @(negedge b_csb) begin
        b_rise = 0;
        b_cmd  = '0;
    end
    always @(posedge b_sck) begin
        if (b_csb === 1'b0) begin
            if (b_rise < 32) b_cmd = {b_cmd[30:0], b_mosi};
            b_rise++;
        end
    end

    // SRAM model plus protocol monitors.
    logic [31:0] mem [0:3];
    int          exp_addr = 0;
    int          wr_cnt = 0;
    int          seq_err = 0;
    int          multi_err = 0;
    int          inv_err = 0;
    bit          ram_prev_low = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            exp_addr = 0;
        end else if (ram_csb === 1'b0) begin
            if (ram_prev_low) multi_err++;
            if (ram_web !== 1'b0) multi_err++;
            if (int'(ram_addr) != exp_addr) seq_err++;
            exp_addr = (int'(ram_addr) + 1) % 4;
            mem[ram_addr[1:0]] = ram_din;
            wr_cnt++;
        end
        ram_prev_low = (ram_csb === 1'b0);
        if (busy === 1'b1 && cpu_reset_o !== 1'b1) inv_err++;
    end

    logic [31:0] exp_word [0:3];

    task automatic t_wait_end(input string tag, input int budget);
        int n = 0;
        while (!(done === 1'b1 || error === 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        t_check(tag, 32'(n < budget), 32'd1);
    endtask

    task automatic t_pulse_boot();
        @(negedge clk);
        boot_req = 1'b1;
        @(negedge clk);
        boot_req = 1'b0;
    endtask

    task automatic t_check_image(input string tag);
        for (int i = 0; i < 4; i++) t_check($sformatf("%s_ram%0d", tag, i), mem[i], exp_word[i]);
        t_check({tag, "_rises"}, 32'(total_rise), 32'(C_EXP_RISES));
        t_check({tag, "_cmd"}, cmd_cap, 32'h03000000);
    endtask

    task automatic t_check_done_seq(input string tag);
        t_check({tag, "_done"}, 32'(done), 32'd1);
        t_check({tag, "_err"}, 32'(error), 32'd0);
        t_check({tag, "_busy"}, 32'(busy), 32'd0);
        t_check({tag, "_cpurst_hold"}, 32'(cpu_reset_o), 32'd1);
        @(negedge clk);
        t_check({tag, "_cpurst_fall"}, 32'(cpu_reset_o), 32'd0);
        t_check({tag, "_csb_idle"}, 32'(spi_csb), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wr_base;
        int n;
        for (int i = 0; i < 16; i++) flash_mem[i] = 8'(i);
        flash_mem[16] = 8'h18; flash_mem[17] = 8'h1C; flash_mem[18] = 8'h20; flash_mem[19] = 8'h24;
        exp_word[0] = 32'h03020100; exp_word[1] = 32'h07060504;
        exp_word[2] = 32'h0B0A0908; exp_word[3] = 32'h0F0E0D0C;
        for (int i = 0; i < 4; i++) mem[i] = '0;

        repeat (3) @(negedge clk);
        t_check("rst_spi_csb", 32'(spi_csb), 32'd1);
        t_check("rst_spi_sck", 32'(spi_sck), 32'd0);
        t_check("rst_spi_mosi", 32'(spi_mosi), 32'd0);
        t_check("rst_ram_csb", 32'(ram_csb), 32'd1);
        t_check("rst_ram_web", 32'(ram_web), 32'd1);
        t_check("rst_ram_addr", 32'(ram_addr), 32'd0);
        t_check("rst_ram_din", ram_din, 32'd0);
        t_check("rst_cpu_reset", 32'(cpu_reset_o), 32'd1);
        t_check("rst_busy", 32'(busy), 32'd0);
        t_check("rst_done", 32'(done), 32'd0);
        t_check("rst_error", 32'(error), 32'd0);

        // First load, including SCK timing.
        total_rise = 0;
        rst = 1'b0;
        @(negedge clk);
        t_check("start_busy", 32'(busy), 32'd1);
        t_check("start_csb", 32'(spi_csb), 32'd0);
        t_wait_end("load1_timeout", 3000);
        t_check("first_rise_delay", 32'(t_rise0 - t_csb_fall), 32'd2);
        t_check("sck_period", 32'(t_rise1 - t_rise0), 32'd4);
        t_check_image("load1");
        t_check_done_seq("load1");
        t_check("ram_single_cycle", 32'(multi_err), 32'd0);
        t_check("b_cmd", b_cmd, 32'h03010000);
        t_check("b_done", 32'(b_done), 32'd1);

        // boot_req after done restarts; boot_req while busy is ignored.
        for (int i = 0; i < 4; i++) mem[i] = '0;
        total_rise = 0;
        t_pulse_boot();
        t_check("reboot_done_clr", 32'(done), 32'd0);
        t_check("reboot_cpurst", 32'(cpu_reset_o), 32'd1);
        t_check("reboot_busy", 32'(busy), 32'd1);
        repeat (100) @(negedge clk);
        t_pulse_boot();
        repeat (3) @(negedge clk);
        t_check("busy_req_ignored", 32'(busy), 32'd1);
        t_wait_end("load2_timeout", 3000);
        t_check_image("load2");
        t_check_done_seq("load2");

        // Asynchronous reset in the middle of word 2.
        for (int i = 0; i < 4; i++) mem[i] = '0;
        wr_base = wr_cnt;
        t_pulse_boot();
        n = 0;
        while (wr_cnt < wr_base + 2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        t_check("midrst_reach_word2", 32'(n < 2000), 32'd1);
        repeat (40) @(negedge clk);
        t_check("midrst_pre_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        t_check("midrst_csb", 32'(spi_csb), 32'd1);
        t_check("midrst_cpurst", 32'(cpu_reset_o), 32'd1);
        t_check("midrst_busy", 32'(busy), 32'd0);
        t_check("midrst_ram_csb", 32'(ram_csb), 32'd1);
        repeat (2) @(negedge clk);
        total_rise = 0;
        rst = 1'b0;
        t_wait_end("load3_timeout", 3000);
        t_check_image("load3");
        t_check_done_seq("load3");
        t_check("write_order", 32'(seq_err), 32'd0);

`ifdef BOOT_CHECKSUM_EN
        // Wrong checksum word: error latches and CPU stays in reset.
        flash_mem[16] = 8'h00; flash_mem[17] = 8'h00; flash_mem[18] = 8'h00; flash_mem[19] = 8'h00;
        t_pulse_boot();
        t_wait_end("badsum_timeout", 3000);
        t_check("badsum_error", 32'(error), 32'd1);
        t_check("badsum_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        t_check("badsum_cpurst", 32'(cpu_reset_o), 32'd1);
        t_check("badsum_busy", 32'(busy), 32'd0);
        flash_mem[16] = 8'h18; flash_mem[17] = 8'h1C; flash_mem[18] = 8'h20; flash_mem[19] = 8'h24;
        total_rise = 0;
        t_pulse_boot();
        t_check("err_clr", 32'(error), 32'd0);
        t_wait_end("goodsum_timeout", 3000);
        t_check_done_seq("goodsum");
`endif

        t_check("ram_single_cycle_all", 32'(multi_err), 32'd0);
        t_check("cpurst_vs_busy", 32'(inv_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tms_spi_boot_loader.md
Name: tms_spi_boot_loader

Overview:
- Upstream stage of the TMS1x00 wrapper: at power-up, copies the TMS program image from external SPI NOR flash into the program SRAM, through that SRAM's write port.
- Holds the CPU in reset until the image is loaded.
- Replaces manual Wishbone program loading for standalone boards; the RAM-port mux between this block and Wishbone lives outside.

Parameters:
- WORDS, 512: number of 32-bit words copied (1..512). RAM addresses 0..WORDS-1.
- CLK_DIV, 2: SCK half-period in wb_clk_i cycles (>=1).
- FLASH_ADDR, 24'h000000: flash byte address of the image start.

Ports:
- wb_clk_i  input  1  system clock.
- wb_rst_i  input  1  reset, asynchronous, active-high.
- boot_req  input  1  single-cycle pulse; restarts the load when in DONE or ERROR.
- spi_csb  output  1  flash chip select, active low.
- spi_sck  output  1  SPI clock, mode 0, idle low.
- spi_mosi  output  1  command/address out, MSB first.
- spi_miso  input  1  data from flash.
- ram_csb  output  1  SRAM chip select, active low.
- ram_web  output  1  SRAM write enable, active low.
- ram_addr  output  9  SRAM word address.
- ram_din  output  32  SRAM write data.
- cpu_reset_o  output  1  high while loading; ORed into the TMS reset.
- busy  output  1  load in progress.
- done  output  1  image loaded successfully.
- error  output  1  checksum failure (only with the optional feature).

Behaviour:
- Reset values: spi_csb=1, spi_sck=0, spi_mosi=0, ram_csb=1, ram_web=1, ram_addr=0, ram_din=0, cpu_reset_o=1, busy=0, done=0, error=0. State is IDLE.
- IDLE: on the first clock after reset deasserts, go to CMD. Set busy=1 and spi_csb=0.
- CMD: shift 32 bits out on MOSI: 8'h03 followed by FLASH_ADDR[23:0].
  - MOSI changes while SCK is low.
  - SCK goes high after CLK_DIV cycles and low after another CLK_DIV cycles.
  - The first rising edge comes CLK_DIV cycles after spi_csb falls.
- READ: shift in 32 bits, sampling MISO on the clock where SCK rises. Byte order is little-endian: flash byte n of the word goes to ram_din[8n+7:8n], and each byte is received MSB first. This matches the TMS fetch mapping (byte_address[1:0]=0 selects bits [7:0]).
- WRITE: one cycle with ram_csb=0, ram_web=0, ram_addr=word index, ram_din=the assembled word.
  - SCK is held low during this cycle; spi_csb stays low.
  - Then ram_csb=1 and ram_web=1 again.
  - If the index is WORDS-1, go to FINISH; otherwise increment the index and return to READ.
- FINISH: spi_csb=1, spi_sck=0, busy=0, done=1. cpu_reset_o falls on the following cycle.
- Total SCK rising edges per load: 32 + 32*WORDS.
- boot_req:
  - In DONE or ERROR: clear done/error, set cpu_reset_o=1, word index=0, then go to CMD.
  - In any other state: ignored.
- Reset mid-load: every output returns to its reset value immediately (spi_csb=1 aborts the flash read), any SRAM write in progress is cut off, and the load restarts from word 0 after release.
- cpu_reset_o is never low while busy=1.

Optional Feature:
- Macro: BOOT_CHECKSUM_EN.
- When defined:
  - After word WORDS-1, read one extra 32-bit word (little-endian, same as data); it is not written to RAM.
  - Compare it with the modulo-2^32 sum of all WORDS data words.
  - Match: done=1, cpu_reset_o=0.
  - Mismatch: error=1, done=0, cpu_reset_o stays 1 until boot_req or reset.
  - SCK rising-edge count becomes 64 + 32*WORDS.
- When undefined: error is tied to 0 and no extra word is read.

Test Plan:
- WORDS=4, CLK_DIV=2, flash model holding bytes 00..0F at address 0 -> MOSI carries 0x03000000, then RAM writes 0x03020100@0, 0x07060504@1, 0x0B0A0908@2, 0x0F0E0D0C@3; then done=1 and cpu_reset_o=0 one cycle later.
- Timing check with CLK_DIV=2 -> SCK period is 4 clocks, first rising edge 2 clocks after spi_csb falls, exactly 160 rising edges, each ram write is a single-cycle low on ram_csb/ram_web.
- Async reset asserted mid-way through word 2 -> spi_csb=1 and cpu_reset_o=1 in the same cycle with no clock edge needed; after release, rewrites start at address 0 and the final contents match the first test.
- boot_req pulsed while busy=1 -> ignored; pulsed after done=1 -> done clears, cpu_reset_o rises, full reload completes.
- FLASH_ADDR=24'h010000 -> MOSI carries 0x03010000.
- BOOT_CHECKSUM_EN defined, WORDS=4, bytes 00..0F, checksum word 0x24201C18 -> done=1. With checksum word 0x00000000 -> error=1, cpu_reset_o remains 1.
